// File: rtl/ttl_gate_tester_if.sv
// Bundle of mode/control, switch, external-chip and result signals for the
// TTL gate tester. The master side is the board/test environment, the slave
// side is the tester block itself.
interface ttl_gate_tester_if #(
  parameter int CH = 4
);
  logic            mode;
  logic            start;
  logic [2:0]      func_sel;
  logic [2*CH-1:0] sw_pin;
  logic [CH-1:0]   dut_a;
  logic [CH-1:0]   dut_b;
  logic [CH-1:0]   dut_y;
  logic [CH-1:0]   led_pin;
  logic [CH-1:0]   err_mask;
  logic            busy;
  logic            pass;
  logic            fail;

  modport master (
    output mode, start, func_sel, sw_pin, dut_y,
    input  dut_a, dut_b, led_pin, err_mask, busy, pass, fail
  );

  modport slave (
    input  mode, start, func_sel, sw_pin, dut_y,
    output dut_a, dut_b, led_pin, err_mask, busy, pass, fail
  );
endinterface

// File: rtl/ttl_gate_tester.sv
// CH-channel 2-input gate tester. In manual mode the switches drive the
// external chip and the LEDs show the reference result; in test mode an FSM
// sweeps the four input vectors through all channels, compares the
// synchronised chip outputs to the latched reference function and reports
// pass/fail plus a sticky per-channel mismatch mask.
module ttl_gate_tester #(
  parameter int CH            = 4,
  parameter int SETTLE_CYCLES = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  ttl_gate_tester_if.slave   bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Reference gate; the two unused selector codes fall back to NAND.
  function automatic logic gate_fn(input logic [2:0] sel, input logic a, input logic b);
    logic r;
    case (sel)
      3'b000:  r = ~(a & b);
      3'b001:  r = a & b;
      3'b010:  r = a | b;
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

  state_t          state_r;
  logic [1:0]      vec_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      func_r;
  logic            start_q_r;
  logic [CH-1:0]   y_meta_r;
  logic [CH-1:0]   y_sync_r;
  logic [CH-1:0]   dut_a_r;
  logic [CH-1:0]   dut_b_r;
  logic [CH-1:0]   led_r;
  logic [CH-1:0]   err_r;
  logic            busy_r;
  logic            pass_r;
  logic            fail_r;

  logic [CH-1:0]   man_a_s;
  logic [CH-1:0]   man_b_s;
  logic [CH-1:0]   man_led_s;
  logic            vec_led_s;
  logic [CH-1:0]   err_next_s;
  logic            start_rise_s;

  assign bus.dut_a    = dut_a_r;
  assign bus.dut_b    = dut_b_r;
  assign bus.led_pin  = led_r;
  assign bus.err_mask = err_r;
  assign bus.busy     = busy_r;
  assign bus.pass     = pass_r;
  assign bus.fail     = fail_r;

  // Unpack the switch pairs and evaluate the live reference per channel.
  always_comb begin
    man_a_s   = '0;
    man_b_s   = '0;
    man_led_s = '0;
    for (int i = 0; i < CH; i++) begin
      man_a_s[i]   = bus.sw_pin[2*i];
      man_b_s[i]   = bus.sw_pin[2*i+1];
      man_led_s[i] = gate_fn(bus.func_sel, bus.sw_pin[2*i], bus.sw_pin[2*i+1]);
    end
  end

  // Test-mode expected value for the current vector and sticky mismatch update.
  always_comb begin
    vec_led_s    = gate_fn(func_r, vec_r[0], vec_r[1]);
    err_next_s   = err_r | (y_sync_r ^ led_r);
    start_rise_s = bus.start & ~start_q_r;
  end

  // Two-flop synchroniser for the asynchronous chip outputs and start edge flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_meta_r  <= '0;
      y_sync_r  <= '0;
      start_q_r <= 1'b0;
    end else begin
      y_meta_r  <= bus.dut_y;
      y_sync_r  <= y_meta_r;
      start_q_r <= bus.start;
    end
  end

  // Mode handling and test sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      vec_r   <= 2'd0;
      cnt_r   <= '0;
      func_r  <= 3'd0;
      dut_a_r <= '0;
      dut_b_r <= '0;
      led_r   <= '0;
      err_r   <= '0;
      busy_r  <= 1'b0;
      pass_r  <= 1'b0;
      fail_r  <= 1'b0;
    end else if (!bus.mode) begin
      // Manual mode overrides any test state immediately.
      state_r <= IDLE;
      vec_r   <= 2'd0;
      cnt_r   <= '0;
      dut_a_r <= man_a_s;
      dut_b_r <= man_b_s;
      led_r   <= man_led_s;
      err_r   <= y_sync_r ^ led_r;
      busy_r  <= 1'b0;
      pass_r  <= 1'b0;
      fail_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          dut_a_r <= '0;
          dut_b_r <= '0;
          led_r   <= '0;
          err_r   <= '0;
          pass_r  <= 1'b0;
          fail_r  <= 1'b0;
          vec_r   <= 2'd0;
          cnt_r   <= '0;
          if (start_rise_s) begin
            func_r  <= bus.func_sel;
            busy_r  <= 1'b1;
            state_r <= DRIVE;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        DRIVE: begin
          dut_a_r <= {CH{vec_r[0]}};
          dut_b_r <= {CH{vec_r[1]}};
          led_r   <= {CH{vec_led_s}};
          cnt_r   <= '0;
          state_r <= SETTLE;
        end
        SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_r <= CHECK;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        CHECK: begin
          err_r <= err_next_s;
          if (vec_r == 2'd3) begin
            busy_r  <= 1'b0;
            pass_r  <= (err_next_s == '0);
            fail_r  <= (err_next_s != '0);
            state_r <= DONE;
          end else begin
            vec_r   <= vec_r + 2'd1;
            state_r <= DRIVE;
          end
        end
        DONE: begin
          // Results and last vector are held until a new start edge.
          if (start_rise_s) begin
            func_r  <= bus.func_sel;
            err_r   <= '0;
            pass_r  <= 1'b0;
            fail_r  <= 1'b0;
            vec_r   <= 2'd0;
            busy_r  <= 1'b1;
            state_r <= DRIVE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttl_gate_tester.sv
// Bench for ttl_gate_tester (CH=4, SETTLE_CYCLES=4). An external chip model
// drives dut_y from a truth table with optional stuck channels; expected
// results come from truth-table lookups over the four test vectors.
module tb_ttl_gate_tester;

  localparam int CH     = 4;
  localparam int SETTLE = 4;
  localparam int RUNLEN = 4 * (SETTLE + 2);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [3:0] chip_tt;
  logic [3:0] stuck0;
  logic [3:0] stuck1;

  ttl_gate_tester_if #(.CH(CH)) bus ();

  ttl_gate_tester #(.CH(CH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truth table of each reference function, indexed by {b,a}.
  function automatic logic [3:0] tt_of(input logic [2:0] f);
    case (f)
      3'd0:    return 4'b0111;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1110;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] model_y(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] y;
    for (int i = 0; i < CH; i++) begin
      y[i] = stuck1[i] | (~stuck0[i] & chip_tt[{b[i], a[i]}]);
    end
    return y;
  endfunction

  function automatic logic [3:0] exp_run_err(input logic [2:0] f);
    logic [3:0] e;
    logic [3:0] t;
    logic [3:0] y;
    e = 4'h0;
    t = tt_of(f);
    for (int v = 0; v < 4; v++) begin
      y = model_y({4{v[0]}}, {4{v[1]}});
      e = e | (y ^ {4{t[v]}});
    end
    return e;
  endfunction

  function automatic logic [3:0] man_led(input logic [2:0] f, input logic [7:0] sw);
    logic [3:0] t;
    logic [3:0] l;
    t = tt_of(f);
    for (int i = 0; i < CH; i++) l[i] = t[{sw[2*i+1], sw[2*i]}];
    return l;
  endfunction

  function automatic logic [3:0] sw_a(input logic [7:0] sw);
    return {sw[6], sw[4], sw[2], sw[0]};
  endfunction

  function automatic logic [3:0] sw_b(input logic [7:0] sw);
    return {sw[7], sw[5], sw[3], sw[1]};
  endfunction

  // External chip: combinational response to the driven pins.
  always_comb begin
    bus.dut_y = '0;
    for (int i = 0; i < CH; i++) begin
      bus.dut_y[i] = stuck1[i] | (~stuck0[i] & chip_tt[{bus.dut_b[i], bus.dut_a[i]}]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.dut_a, bus.dut_b, bus.led_pin, bus.err_mask, bus.busy, bus.pass, bus.fail}, 32'd0);
  endtask

  // Counts busy cycles (starting from pre) until busy drops, bounded.
  task automatic wait_idle(input int pre, output int n);
    logic ok;
    ok = 1'b0;
    n  = pre;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else if (n > 0) begin ok = 1'b1; break; end
    end
    chk("run_finished", ok, 1'b1);
  endtask

  task automatic full_run(input string tag, input logic [2:0] f, input logic [3:0] exp_err);
    int         n;
    logic [3:0] t;
    t = tt_of(f);
    bus.func_sel = f;
    bus.start    = 1'b0;
    @(negedge clk);
    bus.start    = 1'b1;
    wait_idle(0, n);
    chk({tag, "_busy_len"}, n, RUNLEN);
    chk({tag, "_err"}, bus.err_mask, exp_err);
    chk({tag, "_pass"}, bus.pass, exp_err == 4'h0);
    chk({tag, "_fail"}, bus.fail, exp_err != 4'h0);
    chk({tag, "_last_ab"}, {bus.dut_a, bus.dut_b}, 8'hFF);
    chk({tag, "_last_led"}, bus.led_pin, {4{t[3]}});
    repeat (6) @(negedge clk);
    chk({tag, "_no_rerun"}, {bus.busy, bus.pass, bus.err_mask}, {1'b0, exp_err == 4'h0, exp_err});
  endtask

  task automatic manual_step(input string tag, input logic [2:0] f, input logic [7:0] sw);
    logic [3:0] l;
    bus.func_sel = f;
    bus.sw_pin   = sw;
    l = man_led(f, sw);
    @(negedge clk);
    chk({tag, "_led"}, bus.led_pin, l);
    chk({tag, "_ab"}, {bus.dut_a, bus.dut_b}, {sw_a(sw), sw_b(sw)});
    repeat (4) @(negedge clk);
    chk({tag, "_err"}, bus.err_mask, model_y(sw_a(sw), sw_b(sw)) ^ l);
    chk({tag, "_flags"}, {bus.busy, bus.pass, bus.fail}, 3'b000);
  endtask

  initial begin
    int         n;
    logic       quiet;
    logic [2:0] f;
    total = 0;
    bad   = 0;
    chip_tt = 4'b0111;
    stuck0  = 4'h0;
    stuck1  = 4'h0;
    rst_n        = 1'b0;
    bus.mode     = 1'b0;
    bus.start    = 1'b0;
    bus.func_sel = 3'd0;
    bus.sw_pin   = 8'h00;
    #3;
    chk_all_zero("reset_outputs");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual NAND directed case.
    bus.sw_pin = 8'b11_01_10_00;
    @(negedge clk);
    chk("man_nand_led", bus.led_pin, 4'b0111);
    repeat (4) @(negedge clk);
    chk("man_nand_err", bus.err_mask, 4'b0000);

    // Manual randomized cases with random chip truth tables.
    for (int k = 0; k < 6; k++) begin
      chip_tt = 4'($urandom);
      manual_step("man_rand", 3'($urandom_range(0, 7)), 8'($urandom));
    end

    // Mode rise: IDLE with all outputs zero, held start does not launch.
    chip_tt = 4'b0111;
    bus.sw_pin = 8'h00;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.mode = 1'b1;
    @(negedge clk);
    chk_all_zero("mode_rise_zero");
    repeat (5) @(negedge clk);
    chk("mode_rise_no_run", bus.busy, 1'b0);

    // Directed test-mode runs.
    full_run("nand_ok", 3'd0, 4'b0000);
    stuck0 = 4'b0100;
    full_run("stuck_ch2", 3'd0, 4'b0100);
    stuck0 = 4'h0;
    full_run("xor_vs_nand", 3'd4, 4'b1111);

    // Randomized runs against the behavioural model.
    for (int k = 0; k < 4; k++) begin
      f = 3'($urandom_range(0, 7));
      chip_tt = ($urandom_range(0, 1) == 0) ? tt_of(f) : 4'($urandom);
      stuck0  = 4'($urandom) & 4'($urandom);
      stuck1  = 4'($urandom) & 4'($urandom) & ~stuck0;
      full_run("rand_run", f, exp_run_err(f));
    end
    chip_tt = 4'b0111;
    stuck0  = 4'h0;
    stuck1  = 4'h0;

    // Restart attempt and func_sel change during a run have no effect.
    bus.func_sel = 3'd0;
    bus.start    = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrun_busy", bus.busy, 1'b1);
    bus.start    = 1'b0;
    bus.func_sel = 3'd4;
    @(negedge clk);
    bus.start = 1'b1;
    wait_idle(6, n);
    chk("midrun_len", n, RUNLEN);
    chk("midrun_pass", {bus.pass, bus.fail, bus.err_mask}, {1'b1, 1'b0, 4'h0});

    // Mode drop on the 10th busy cycle.
    bus.func_sel = 3'd2;
    bus.sw_pin   = 8'b01_10_00_11;
    bus.start    = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (10) @(negedge clk);
    chk("drop_busy10", bus.busy, 1'b1);
    bus.mode = 1'b0;
    @(negedge clk);
    chk("drop_flags", {bus.busy, bus.pass, bus.fail}, 3'b000);
    chk("drop_manual_led", bus.led_pin, man_led(3'd2, 8'b01_10_00_11));

    // Asynchronous reset during SETTLE.
    bus.mode     = 1'b1;
    bus.func_sel = 3'd0;
    bus.start    = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.led_pin !== 4'h0) quiet = 1'b0;
    end
    chk("post_reset_quiet", quiet, 1'b1);
    full_run("post_reset", 3'd0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
